// File: rtl/dmem_arbiter_if.sv
// Request, grant, read-return and memory-side signals between the core MEM stage,
// the DMA/debug loader, the data memory and dmem_arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned DMEM_ADDR_WIDTH = 12,
    parameter int unsigned DMEM_WORD_WIDTH = 16,
    parameter int unsigned GNT_CNT_WIDTH   = 16
);
    logic                       in_core_req;
    logic                       in_core_we;
    logic [DMEM_ADDR_WIDTH-1:0] in_core_addr;
    logic [DMEM_WORD_WIDTH-1:0] in_core_wr_word;
    logic                       out_core_stall;
    logic                       out_core_rd_valid;
    logic [DMEM_WORD_WIDTH-1:0] out_core_rd_word;

    logic                       in_dma_req;
    logic                       in_dma_we;
    logic [DMEM_ADDR_WIDTH-1:0] in_dma_addr;
    logic [DMEM_WORD_WIDTH-1:0] in_dma_wr_word;
    logic                       out_dma_gnt;
    logic                       out_dma_rd_valid;
    logic [DMEM_WORD_WIDTH-1:0] out_dma_rd_word;
    logic [GNT_CNT_WIDTH-1:0]   out_dma_gnt_count;

    logic [DMEM_ADDR_WIDTH-1:0] out_mem_rd_addr;
    logic [DMEM_ADDR_WIDTH-1:0] out_mem_wr_addr;
    logic [DMEM_WORD_WIDTH-1:0] out_mem_wr_word;
    logic                       out_mem_write_en;
    logic [DMEM_WORD_WIDTH-1:0] in_mem_rd_word;

    // Arbiter side.
    modport slave (
        input  in_core_req, in_core_we, in_core_addr, in_core_wr_word,
        input  in_dma_req, in_dma_we, in_dma_addr, in_dma_wr_word,
        input  in_mem_rd_word,
        output out_core_stall, out_core_rd_valid, out_core_rd_word,
        output out_dma_gnt, out_dma_rd_valid, out_dma_rd_word, out_dma_gnt_count,
        output out_mem_rd_addr, out_mem_wr_addr, out_mem_wr_word, out_mem_write_en
    );

    // Requesters and memory side.
    modport master (
        output in_core_req, in_core_we, in_core_addr, in_core_wr_word,
        output in_dma_req, in_dma_we, in_dma_addr, in_dma_wr_word,
        output in_mem_rd_word,
        input  out_core_stall, out_core_rd_valid, out_core_rd_word,
        input  out_dma_gnt, out_dma_rd_valid, out_dma_rd_word, out_dma_gnt_count,
        input  out_mem_rd_addr, out_mem_wr_addr, out_mem_wr_word, out_mem_write_en
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Fixed-priority data memory arbiter: core first, DMA forced in after MAX_WAIT denials.
// Read returns arrive one cycle after the grant and are steered to the issuing requester.
module dmem_arbiter #(
    parameter int unsigned DMEM_ADDR_WIDTH = 12,
    parameter int unsigned DMEM_WORD_WIDTH = 16,
    parameter int unsigned MAX_WAIT        = 4,
    parameter int unsigned WAIT_CNT_WIDTH  = 3,
    parameter int unsigned GNT_CNT_WIDTH   = 16
) (
    input logic           clock,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LIMIT = WAIT_CNT_WIDTH'(MAX_WAIT);

    owner_e                     owner_q, owner_d;
    logic [WAIT_CNT_WIDTH-1:0]  wait_q, wait_d;
    logic [GNT_CNT_WIDTH-1:0]   gnt_cnt_q, gnt_cnt_d;

    logic                       force_dma;
    logic                       gnt_core;
    logic                       gnt_dma;
    logic [DMEM_ADDR_WIDTH-1:0] addr_sel;
    logic [DMEM_WORD_WIDTH-1:0] wdata_sel;
    logic                       we_sel;

    assign force_dma = bus.in_dma_req && (wait_q == WAIT_LIMIT);
    assign gnt_core  = bus.in_core_req && !force_dma;
    assign gnt_dma   = bus.in_dma_req && (!bus.in_core_req || force_dma);

    always_comb begin
        addr_sel  = '0;
        wdata_sel = '0;
        we_sel    = 1'b0;
        if (gnt_core) begin
            addr_sel  = bus.in_core_addr;
            wdata_sel = bus.in_core_wr_word;
            we_sel    = bus.in_core_we;
        end else if (gnt_dma) begin
            addr_sel  = bus.in_dma_addr;
            wdata_sel = bus.in_dma_wr_word;
            we_sel    = bus.in_dma_we;
        end
    end

    assign bus.out_core_stall   = bus.in_core_req && !gnt_core;
    assign bus.out_dma_gnt      = gnt_dma;
    assign bus.out_mem_rd_addr  = addr_sel;
    assign bus.out_mem_wr_addr  = addr_sel;
    assign bus.out_mem_wr_word  = wdata_sel;
    assign bus.out_mem_write_en = we_sel;

    always_comb begin
        owner_d   = OWN_NONE;
        wait_d    = '0;
        gnt_cnt_d = gnt_cnt_q;

        if (gnt_core && !bus.in_core_we) begin
            owner_d = OWN_CORE;
        end else if (gnt_dma && !bus.in_dma_we) begin
            owner_d = OWN_DMA;
        end

        // Any cycle without a pending, denied DMA request restarts the starvation window.
        if (bus.in_dma_req && !gnt_dma) begin
            wait_d = (wait_q == WAIT_LIMIT) ? wait_q : wait_q + WAIT_CNT_WIDTH'(1);
        end

        if (gnt_dma && (gnt_cnt_q != '1)) begin
            gnt_cnt_d = gnt_cnt_q + GNT_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q   <= OWN_NONE;
            wait_q    <= '0;
            gnt_cnt_q <= '0;
        end else begin
            owner_q   <= owner_d;
            wait_q    <= wait_d;
            gnt_cnt_q <= gnt_cnt_d;
        end
    end

    assign bus.out_core_rd_valid = (owner_q == OWN_CORE);
    assign bus.out_dma_rd_valid  = (owner_q == OWN_DMA);
    assign bus.out_core_rd_word  = (owner_q == OWN_CORE) ? bus.in_mem_rd_word : '0;
    assign bus.out_dma_rd_word   = (owner_q == OWN_DMA)  ? bus.in_mem_rd_word : '0;
    assign bus.out_dma_gnt_count = gnt_cnt_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: one-cycle memory model plus a read-return scoreboard.
module tb_dmem_arbiter;
    localparam int unsigned AW = 12;
    localparam int unsigned WW = 16;
    localparam int unsigned GW = 16;

    typedef struct {
        bit          dma;
        logic [WW-1:0] word;
    } rd_exp_t;

    logic      clock;
    logic      reset;
    logic [WW-1:0] img [0:(1<<AW)-1];
    rd_exp_t   exp_q [$];
    int        n_checks;
    int        n_fail;

    dmem_arbiter_if #(.DMEM_ADDR_WIDTH(AW), .DMEM_WORD_WIDTH(WW), .GNT_CNT_WIDTH(GW)) bus ();

    dmem_arbiter #(
        .DMEM_ADDR_WIDTH(AW),
        .DMEM_WORD_WIDTH(WW),
        .MAX_WAIT(4),
        .WAIT_CNT_WIDTH(3),
        .GNT_CNT_WIDTH(GW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data memory: read data valid the cycle after the address.
    always @(posedge clock) bus.in_mem_rd_word <= img[bus.out_mem_rd_addr];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_core_req = 1'b0; bus.in_core_we = 1'b0;
        bus.in_core_addr = '0;  bus.in_core_wr_word = '0;
        bus.in_dma_req = 1'b0;  bus.in_dma_we = 1'b0;
        bus.in_dma_addr = '0;   bus.in_dma_wr_word = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        #2;
        n_checks++; if (bus.out_core_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_core_valid: got %b expected 0", bus.out_core_rd_valid); end
        n_checks++; if (bus.out_dma_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dma_valid: got %b expected 0", bus.out_dma_rd_valid); end
        n_checks++; if (bus.out_core_rd_word !== 16'h0) begin n_fail++; $display("FAIL rst_core_word: got %h expected 0000", bus.out_core_rd_word); end
        n_checks++; if (bus.out_dma_rd_word !== 16'h0) begin n_fail++; $display("FAIL rst_dma_word: got %h expected 0000", bus.out_dma_rd_word); end
        n_checks++; if (bus.out_dma_gnt_count !== 16'h0) begin n_fail++; $display("FAIL rst_gnt_count: got %h expected 0000", bus.out_dma_gnt_count); end
        n_checks++; if ({bus.out_mem_write_en, bus.out_mem_rd_addr, bus.out_mem_wr_addr, bus.out_mem_wr_word} !== '0)
            begin n_fail++; $display("FAIL rst_idle_mem: got we=%b ra=%h wa=%h wd=%h expected all 0", bus.out_mem_write_en, bus.out_mem_rd_addr, bus.out_mem_wr_addr, bus.out_mem_wr_word); end
        n_checks++; if ({bus.out_core_stall, bus.out_dma_gnt} !== 2'b00) begin n_fail++; $display("FAIL rst_idle_gnt: got stall=%b gnt=%b expected 0 0", bus.out_core_stall, bus.out_dma_gnt); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_core_read();
        rd_exp_t e;
        bus.in_core_req = 1'b1; bus.in_core_we = 1'b0; bus.in_core_addr = 12'h010;
        #2;
        n_checks++; if (bus.out_mem_rd_addr !== 12'h010) begin n_fail++; $display("FAIL core_rd_addr: got %h expected 010", bus.out_mem_rd_addr); end
        n_checks++; if (bus.out_mem_write_en !== 1'b0) begin n_fail++; $display("FAIL core_rd_we: got %b expected 0", bus.out_mem_write_en); end
        n_checks++; if (bus.out_core_stall !== 1'b0) begin n_fail++; $display("FAIL core_rd_stall: got %b expected 0", bus.out_core_stall); end
        exp_q.push_back('{dma: 1'b0, word: 16'hBEEF});
        step();
        idle_inputs();
        n_checks++; if (bus.out_dma_rd_valid !== 1'b0) begin n_fail++; $display("FAIL core_rd_dma_valid: got %b expected 0", bus.out_dma_rd_valid); end
        n_checks++;
        if (bus.out_core_rd_valid !== 1'b1 || exp_q.size() == 0) begin
            n_fail++; $display("FAIL core_rd_valid: got %b expected 1", bus.out_core_rd_valid);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            if (e.dma || bus.out_core_rd_word !== e.word) begin
                n_fail++; $display("FAIL core_rd_word: got %h expected %h", bus.out_core_rd_word, e.word);
            end
        end
        step();
    endtask

    task automatic test_dma_write();
        bus.in_dma_req = 1'b1; bus.in_dma_we = 1'b1;
        bus.in_dma_addr = 12'h020; bus.in_dma_wr_word = 16'h1234;
        #2;
        n_checks++; if (bus.out_dma_gnt !== 1'b1) begin n_fail++; $display("FAIL dma_wr_gnt: got %b expected 1", bus.out_dma_gnt); end
        n_checks++; if (bus.out_mem_write_en !== 1'b1) begin n_fail++; $display("FAIL dma_wr_we: got %b expected 1", bus.out_mem_write_en); end
        n_checks++; if (bus.out_mem_wr_addr !== 12'h020) begin n_fail++; $display("FAIL dma_wr_addr: got %h expected 020", bus.out_mem_wr_addr); end
        n_checks++; if (bus.out_mem_wr_word !== 16'h1234) begin n_fail++; $display("FAIL dma_wr_word: got %h expected 1234", bus.out_mem_wr_word); end
        step();
        idle_inputs();
        n_checks++; if ({bus.out_core_rd_valid, bus.out_dma_rd_valid} !== 2'b00) begin n_fail++; $display("FAIL dma_wr_no_return: got %b%b expected 00", bus.out_core_rd_valid, bus.out_dma_rd_valid); end
        n_checks++; if (bus.out_dma_gnt_count !== 16'd1) begin n_fail++; $display("FAIL dma_wr_count: got %0d expected 1", bus.out_dma_gnt_count); end
        step();
    endtask

    task automatic test_contention();
        logic [GW-1:0] c0;
        logic          exp_g;
        logic [AW-1:0] exp_a;
        c0 = bus.out_dma_gnt_count;
        for (int i = 0; i < 10; i++) begin
            bus.in_core_req = 1'b1; bus.in_core_we = 1'b1;
            bus.in_core_addr = 12'h100 + AW'(i); bus.in_core_wr_word = 16'hC000 + WW'(i);
            bus.in_dma_req = 1'b1; bus.in_dma_we = 1'b1;
            bus.in_dma_addr = 12'h200 + AW'(i); bus.in_dma_wr_word = 16'hD000 + WW'(i);
            #2;
            exp_g = ((i % 5) == 4);
            exp_a = exp_g ? 12'h200 + AW'(i) : 12'h100 + AW'(i);
            n_checks++; if (bus.out_dma_gnt !== exp_g) begin n_fail++; $display("FAIL cont_gnt[%0d]: got %b expected %b", i, bus.out_dma_gnt, exp_g); end
            n_checks++; if (bus.out_core_stall !== exp_g) begin n_fail++; $display("FAIL cont_stall[%0d]: got %b expected %b", i, bus.out_core_stall, exp_g); end
            n_checks++; if (bus.out_mem_wr_addr !== exp_a) begin n_fail++; $display("FAIL cont_addr[%0d]: got %h expected %h", i, bus.out_mem_wr_addr, exp_a); end
            step();
        end
        idle_inputs();
        n_checks++; if (bus.out_dma_gnt_count !== c0 + GW'(2)) begin n_fail++; $display("FAIL cont_count: got %0d expected %0d", bus.out_dma_gnt_count, c0 + GW'(2)); end
        step();
    endtask

    task automatic test_alternating();
        rd_exp_t e;
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            if (i % 2 == 0) begin
                bus.in_core_req = 1'b1; bus.in_core_addr = 12'h001;
                exp_q.push_back('{dma: 1'b0, word: img[12'h001]});
            end else begin
                bus.in_dma_req = 1'b1; bus.in_dma_addr = 12'h002;
                exp_q.push_back('{dma: 1'b1, word: img[12'h002]});
            end
            #2;
            n_checks++; if (bus.out_dma_gnt !== (i % 2 == 1)) begin n_fail++; $display("FAIL alt_gnt[%0d]: got %b expected %b", i, bus.out_dma_gnt, (i % 2 == 1)); end
            step();
            n_checks++; if (bus.out_core_rd_valid && bus.out_dma_rd_valid) begin n_fail++; $display("FAIL alt_both_valid[%0d]: got 11 expected at most one", i); end
            n_checks++;
            if (!(bus.out_core_rd_valid || bus.out_dma_rd_valid)) begin
                n_fail++; $display("FAIL alt_missing[%0d]: got no rd_valid expected one", i);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end else if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL alt_unexpected[%0d]: got rd_valid expected none", i);
            end else begin
                e = exp_q.pop_front();
                if (bus.out_dma_rd_valid !== e.dma || (e.dma ? bus.out_dma_rd_word : bus.out_core_rd_word) !== e.word)
                    begin n_fail++; $display("FAIL alt_return[%0d]: got dma=%b core=%h dmaw=%h expected dma=%b word=%h", i, bus.out_dma_rd_valid, bus.out_core_rd_word, bus.out_dma_rd_word, e.dma, e.word); end
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_release();
        logic [8:0] dreq;
        logic [8:0] egnt;
        dreq = 9'b111110111;  // bit i = cycle i
        egnt = 9'b100000000;
        for (int i = 0; i < 9; i++) begin
            bus.in_core_req = 1'b1; bus.in_core_we = 1'b1; bus.in_core_addr = 12'h300;
            bus.in_dma_req = dreq[i]; bus.in_dma_we = 1'b1; bus.in_dma_addr = 12'h301;
            #2;
            n_checks++; if (bus.out_dma_gnt !== egnt[i]) begin n_fail++; $display("FAIL rel_gnt[%0d]: got %b expected %b", i, bus.out_dma_gnt, egnt[i]); end
            n_checks++; if (bus.out_core_stall !== egnt[i]) begin n_fail++; $display("FAIL rel_stall[%0d]: got %b expected %b", i, bus.out_core_stall, egnt[i]); end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            bus.in_core_req = 1'b1; bus.in_core_we = 1'b1; bus.in_core_addr = 12'h400;
            bus.in_dma_req = 1'b1; bus.in_dma_we = 1'b1; bus.in_dma_addr = 12'h401;
            step();
        end
        reset = 1'b1;
        bus.in_core_we = 1'b0; bus.in_core_addr = 12'h010;
        #2;
        n_checks++; if (bus.out_core_stall !== 1'b0) begin n_fail++; $display("FAIL rmid_stall: got %b expected 0", bus.out_core_stall); end
        n_checks++; if (bus.out_mem_rd_addr !== 12'h010) begin n_fail++; $display("FAIL rmid_rd_addr: got %h expected 010", bus.out_mem_rd_addr); end
        step();
        reset = 1'b0;
        n_checks++; if ({bus.out_core_rd_valid, bus.out_dma_rd_valid} !== 2'b00) begin n_fail++; $display("FAIL rmid_valid: got %b%b expected 00", bus.out_core_rd_valid, bus.out_dma_rd_valid); end
        n_checks++; if (bus.out_core_rd_word !== 16'h0) begin n_fail++; $display("FAIL rmid_word: got %h expected 0000", bus.out_core_rd_word); end
        n_checks++; if (bus.out_dma_gnt_count !== 16'd0) begin n_fail++; $display("FAIL rmid_count: got %0d expected 0", bus.out_dma_gnt_count); end
        bus.in_core_we = 1'b1; bus.in_core_addr = 12'h400;
        for (int i = 0; i < 5; i++) begin
            #2;
            n_checks++; if (bus.out_dma_gnt !== (i == 4)) begin n_fail++; $display("FAIL rmid_gnt[%0d]: got %b expected %b", i, bus.out_dma_gnt, (i == 4)); end
            step();
        end
        idle_inputs();
        n_checks++; if (bus.out_dma_gnt_count !== 16'd1) begin n_fail++; $display("FAIL rmid_count_after: got %0d expected 1", bus.out_dma_gnt_count); end
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < (1 << AW); i++) img[i] = WW'(i * 7) ^ 16'h5A5A;
        img[12'h010] = 16'hBEEF;
        img[12'h001] = 16'h1111;
        img[12'h002] = 16'h2222;
        reset = 1'b1;
        idle_inputs();

        test_reset();
        test_core_read();
        test_dma_write();
        test_contention();
        test_alternating();
        test_release();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
